// File: rtl/collision_manager_if.sv
// Frame-level handshake between the player/obstacle stages and the collision manager.
// slave is the manager side; master is whoever drives frames, hazards and player pose.
interface collision_manager_if #(
  parameter int NUM_LANES = 3,
  parameter int SCORE_W   = 16
);
  logic                 frame_done;
  logic                 start_pulse;
  logic [1:0]           lane;
  logic                 jump_clear;
  logic                 slide_clear;
  logic [NUM_LANES-1:0] hazard_low;
  logic [NUM_LANES-1:0] hazard_high;
  logic [NUM_LANES-1:0] hazard_block;
  logic                 game_active;
  logic                 game_over;
  logic [2:0]           lives;
  logic                 hit_pulse;
  logic                 player_blink;
  logic [SCORE_W-1:0]   score;

  modport slave (
    input  frame_done, start_pulse, lane, jump_clear, slide_clear,
           hazard_low, hazard_high, hazard_block,
    output game_active, game_over, lives, hit_pulse, player_blink, score
  );

  modport master (
    output frame_done, start_pulse, lane, jump_clear, slide_clear,
           hazard_low, hazard_high, hazard_block,
    input  game_active, game_over, lives, hit_pulse, player_blink, score
  );
endinterface

// File: rtl/collision_manager.sv
// Per-frame collision check of the player against lane hazards; owns game state,
// lives, post-hit invulnerability and the saturating frame-count score.
module collision_lane (
  input  logic low,
  input  logic high,
  input  logic block,
  input  logic jump_clear,
  input  logic slide_clear,
  output logic hit
);
  assign hit = block | (low & ~jump_clear) | (high & ~slide_clear);
endmodule

module collision_manager #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_W       = 16,
  parameter int NUM_LANES     = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  collision_manager_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, INVULN, OVER} state_t;

  state_t               state;
  logic [2:0]           lives;
  logic [7:0]           invuln_cnt;
  logic [SCORE_W-1:0]   score;
  logic                 start_pending;
  logic                 hit_pulse;
  logic                 game_active;
  logic                 game_over;

  logic [NUM_LANES-1:0] lane_hit;
  logic [1:0]           lane_sel;
  logic                 hit;
  logic [SCORE_W-1:0]   score_inc;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      collision_lane u_lane (
        .low         (bus.hazard_low[g]),
        .high        (bus.hazard_high[g]),
        .block       (bus.hazard_block[g]),
        .jump_clear  (bus.jump_clear),
        .slide_clear (bus.slide_clear),
        .hit         (lane_hit[g])
      );
    end
  endgenerate

  // Lane code 3 is not a real lane; the player stage treats it as centre.
  assign lane_sel  = (bus.lane == 2'd3) ? 2'd1 : bus.lane;
  assign hit       = lane_hit[lane_sel];
  assign score_inc = (&score) ? score : score + SCORE_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      lives         <= 3'(LIVES);
      invuln_cnt    <= '0;
      score         <= '0;
      start_pending <= 1'b0;
      hit_pulse     <= 1'b0;
      game_active   <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      // A press landing on the frame edge itself is held for the next frame.
      if (bus.start_pulse)     start_pending <= 1'b1;
      else if (bus.frame_done) start_pending <= 1'b0;

      if (bus.frame_done) begin
        case (state)
          IDLE, OVER: begin
            if (start_pending) begin
              state       <= RUN;
              lives       <= 3'(LIVES);
              score       <= '0;
              invuln_cnt  <= '0;
              game_active <= 1'b1;
              game_over   <= 1'b0;
            end
          end
          RUN: begin
            score <= score_inc;
            if (hit) begin
              hit_pulse <= 1'b1;
              if (lives > 3'd1) begin
                state      <= INVULN;
                lives      <= lives - 3'd1;
                invuln_cnt <= 8'(INVULN_FRAMES);
              end else begin
                state       <= OVER;
                lives       <= '0;
                game_active <= 1'b0;
                game_over   <= 1'b1;
              end
            end
          end
          INVULN: begin
            score      <= score_inc;
            invuln_cnt <= invuln_cnt - 8'd1;
            if (invuln_cnt == 8'd1) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.game_active  = game_active;
  assign bus.game_over    = game_over;
  assign bus.lives        = lives;
  assign bus.hit_pulse    = hit_pulse;
  assign bus.score        = score;
  assign bus.player_blink = (state == INVULN) & invuln_cnt[2];
endmodule
